// File: rtl/spi_slave_sync_pkg.sv
// Shared types and helpers for the oversampled SPI slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Width of a counter that indexes bits 0..width-1 of a word
    function automatic int spi_bits_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Host-side word interface of the SPI slave: tx/rx valid-ready plus status pulses.
// Latency: n/a (wires only).
// Backpressure: tx_ready low while the holding register is full; rx_valid holds until rx_ready.
interface spi_slave_sync_if #(
    parameter int WIDTH = 13
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             tx_underrun;
    logic             rx_overrun;
    logic             frame_err;
    logic             busy;

    // Host side: supplies transmit words and consumes received words
    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, frame_err, busy
    );

    // SPI slave side
    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_sync_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall event pulses.
// Latency: pulse is visible STAGES cycles after the pin edge and acted upon one cycle later.
// Backpressure: none; one pulse per synchronised edge.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain plus one extra flop to compare against for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise =  sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] &  prev_q;
endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave fully in the clk domain: oversampled pins, all CPOL/CPHA modes, multi-word frames.
// Latency: SYNC_STAGES+1 cycles pin-to-event; miso one cycle later; rx_valid one cycle after last sample.
// Backpressure: one-word tx lookahead via tx_ready; unread rx words are overwritten with rx_overrun.
module spi_slave_sync #(
    parameter int WIDTH       = 13,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic miso,
    output logic miso_oe,
    spi_slave_sync_if.slave host
);
    import spi_pkg::*;

    localparam int            BW       = spi_bits_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;
    logic leading, trailing;

    spi_state_t state_q, state_d;
    logic cs_start, cs_end, sample_ev, drive_ev;

    logic [WIDTH-1:0] hold_q, tx_sr, rx_data_q, rx_next;
    logic [WIDTH-2:0] rx_sr;
    logic [BW-1:0]    bit_cnt;
    logic hold_full, rx_valid_q, underrun_q, overrun_q, ferr_q, oe_q;
    logic word_start, word_done, tx_fire, rx_take;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
        .clk (clk),
        .rst (rst),
        .din (sclk),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    // cs_n idles high, so reset the chain to the deasserted level
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .din (cs_n),
        .rise(cs_rise),
        .fall(cs_fall)
    );

    // mosi gets the same depth as sclk (no edge flop) so its value lines up with the sclk event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_sync <= '0;
        else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign leading  = CPOL ? sclk_fall : sclk_rise;
    assign trailing = CPOL ? sclk_rise : sclk_fall;

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle events; sclk edges outside a frame are dropped
    always_comb begin
        state_d   = state_q;
        cs_start  = 1'b0;
        cs_end    = 1'b0;
        sample_ev = 1'b0;
        drive_ev  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d  = ACTIVE;
                    cs_start = 1'b1;
                    drive_ev = !CPHA;  // CPHA=0 puts the MSB out as soon as CS asserts
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    cs_end  = 1'b1;
                end else begin
                    sample_ev = CPHA ? trailing : leading;
                    drive_ev  = CPHA ? leading  : trailing;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_start = drive_ev && (bit_cnt == '0);
    assign word_done  = sample_ev && (bit_cnt == LAST_BIT);
    assign rx_next    = {rx_sr, mosi_s};
    assign tx_fire    = host.tx_valid && !hold_full;
    assign rx_take    = rx_valid_q && host.rx_ready;

    // One-word transmit holding register, emptied by each word start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else begin
            if (word_start && hold_full) hold_full <= 1'b0;
            if (tx_fire) begin
                hold_q    <= host.tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    // Transmit shifter; its MSB is the registered miso
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr      <= '0;
            oe_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (cs_start) oe_q <= 1'b1;
            if (cs_end) begin
                oe_q  <= 1'b0;
                tx_sr <= '0;
            end else if (word_start) begin
                if (hold_full) begin
                    tx_sr <= hold_q;
                end else begin
                    tx_sr      <= '0;
                    underrun_q <= 1'b1;
                end
            end else if (drive_ev) begin
                tx_sr <= tx_sr << 1;
            end
        end
    end

    // Receive shifter, bit counter, word completion and abort detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt    <= '0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            if (cs_end) begin
                ferr_q  <= (bit_cnt != '0);
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (sample_ev) begin
                rx_sr <= rx_next[WIDTH-2:0];
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    rx_data_q <= rx_next;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
            // A completion beats a same-cycle read: the new word stays valid, nothing was lost
            if (word_done) begin
                rx_valid_q <= 1'b1;
                overrun_q  <= rx_valid_q && !host.rx_ready;
            end else if (rx_take) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign miso             = tx_sr[WIDTH-1];
    assign miso_oe          = oe_q;
    assign host.tx_ready    = !hold_full;
    assign host.rx_data     = rx_data_q;
    assign host.rx_valid    = rx_valid_q;
    assign host.tx_underrun = underrun_q;
    assign host.rx_overrun  = overrun_q;
    assign host.frame_err   = ferr_q;
    assign host.busy        = (state_q == ACTIVE);
endmodule
